// File: rtl/iis_pkg.sv
// Shared types and defaults for the I2S capture receiver.
package iis_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // LRCK level that selects each channel
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int DEF_DATA_W  = 24;
    localparam int DEF_TIMEOUT = 256;
    localparam int DEF_CNT_W   = 6;

endpackage

// File: rtl/iis_sync.sv
// Brings BCLK/LRCK/SDIN into the system clock domain and flags BCLK rising edges.
module iis_sync (
    input  logic clkin,
    input  logic reset,
    input  logic bclk,
    input  logic lrck,
    input  logic sdin,
    output logic rise,
    output logic lrck_s,
    output logic sdin_s
);

    logic [2:0] bclk_q;
    logic [1:0] lrck_q;
    logic [1:0] sdin_q;

    // two-flop synchronizers, plus a third BCLK stage for edge detection
    always_ff @(posedge clkin) begin
        if (reset) begin
            bclk_q <= '0;
            lrck_q <= '0;
            sdin_q <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], bclk};
            lrck_q <= {lrck_q[0], lrck};
            sdin_q <= {sdin_q[0], sdin};
        end
    end

    assign rise   = bclk_q[1] & ~bclk_q[2];
    assign lrck_s = lrck_q[1];
    assign sdin_s = sdin_q[1];

endmodule

// File: rtl/iis_rx.sv
// I2S slave receiver: deserializes Philips I2S into left/right pairs on a
// valid/ready interface, with lock tracking, overflow and short-slot flags.
module iis_rx
    import iis_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              sdin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              locked,
    output logic              overflow,
    output logic              slot_err
);

    localparam int               WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic               rise, lrck_s, sdin_s;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg, left_hold, word;
    logic               lr_prev, have_left;
    logic [WD_W-1:0]    wd;
    logic               slot_close, short_slot;
    logic               tmo, run_close, pair_done;

    iis_sync u_sync (
        .clkin  (clkin),
        .reset  (reset),
        .bclk   (bclk),
        .lrck   (lrck),
        .sdin   (sdin),
        .rise   (rise),
        .lrck_s (lrck_s),
        .sdin_s (sdin_s)
    );

    // shift register including the bit arriving on this rise; bits past DATA_W are dropped
    always_comb begin
        word = shreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(bit_cnt) == DATA_W - 1 - i) word[i] = sdin_s;
        end
    end

    // the rise that sees a new LRCK level carries the last bit of the old slot
    assign slot_close = rise & (lrck_s != lr_prev);
    assign short_slot = (int'(bit_cnt) + 1) < DATA_W;

    // state register
    always_ff @(posedge clkin) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // next state and per-cycle frame events
    always_comb begin
        state_next = state;
        tmo        = 1'b0;
        run_close  = 1'b0;
        pair_done  = 1'b0;
        case (state)
            HUNT: if (slot_close) state_next = RUN;
            RUN: begin
                if (wd == WD_MAX) begin
                    tmo        = 1'b1;
                    state_next = HUNT;
                end else if (slot_close) begin
                    run_close = 1'b1;
                    pair_done = (lr_prev == CH_RIGHT) && have_left;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    // deserializer, watchdog, pairing and output register
    always_ff @(posedge clkin) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            lr_prev   <= 1'b0;
            have_left <= 1'b0;
            left_hold <= '0;
            wd        <= '0;
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
            slot_err  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            slot_err <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (rise)              wd <= '0;
            else if (wd != WD_MAX) wd <= wd + 1'b1;

            if (rise) begin
                if (slot_close) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    lr_prev <= lrck_s;
                end else begin
                    shreg <= word;
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (tmo) begin
                have_left <= 1'b0;
                locked    <= 1'b0;
            end

            if (run_close) begin
                slot_err <= short_slot;
                if (lr_prev == CH_LEFT) begin
                    left_hold <= word;
                    have_left <= 1'b1;
                end
            end

            // a held pair that is not being taken this cycle wins over the new one
            if (pair_done) begin
                have_left <= 1'b0;
                locked    <= 1'b1;
                if (!out_valid || out_ready) begin
                    out_left  <= left_hold;
                    out_right <= word;
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iis_rx.sv
// Directed bench for iis_rx: a table of frames plus hand-built corner sequences.
module tb_iis_rx;
    import iis_pkg::*;

    localparam int DW = 24;

    logic          clkin = 1'b0;
    logic          reset = 1'b1;
    logic          bclk  = 1'b0;
    logic          lrck  = 1'b0;
    logic          sdin  = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid, locked, overflow, slot_err;
    logic [DW-1:0] out_left, out_right;

    iis_rx #(.DATA_W(DW), .TIMEOUT(256), .CNT_W(6)) dut (
        .clkin     (clkin),
        .reset     (reset),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdin      (sdin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .locked    (locked),
        .overflow  (overflow),
        .slot_err  (slot_err)
    );

    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;
    int bhalf    = 4;
    logic carry  = 1'b0;
    logic [DW-1:0] cap_l[$];
    logic [DW-1:0] cap_r[$];
    int ovf_cnt  = 0;
    int serr_cnt = 0;

    typedef struct {
        int          n;
        int          bh;
        logic [63:0] l;
        logic [63:0] r;
        logic [23:0] el;
        logic [23:0] er;
        int          serr;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: samples mid-cycle, records transfers and pulses, checks hold stability
    logic          pv = 1'b0, prdy = 1'b0;
    logic [DW-1:0] pl = '0, pr = '0;
    always begin
        @(negedge clkin);
        #2;
        if (!reset) begin
            if (pv && !prdy) begin
                chk("hold valid", 64'(out_valid), 64'd1);
                chk("hold left", 64'(out_left), 64'(pl));
                chk("hold right", 64'(out_right), 64'(pr));
            end
            if (out_valid && out_ready) begin
                cap_l.push_back(out_left);
                cap_r.push_back(out_right);
            end
            if (overflow) ovf_cnt++;
            if (slot_err) serr_cnt++;
        end
        pv   = out_valid & ~reset;
        prdy = out_ready;
        pl   = out_left;
        pr   = out_right;
    end

    // one BCLK period: data and LRCK change on the falling edge
    task automatic send_bit(input logic lr, input logic b);
        bclk = 1'b0; lrck = lr; sdin = b;
        repeat (bhalf) @(negedge clkin);
        bclk = 1'b1;
        repeat (bhalf) @(negedge clkin);
    endtask

    // one n-bit slot, MSB first, delayed one BCLK behind LRCK
    task automatic send_slot(input logic ch, input logic [63:0] w, input int n, input bit skip0);
        for (int j = (skip0 ? 1 : 0); j < n; j++) send_bit(ch, (j == 0) ? carry : w[n-j]);
        carry = w[0];
    endtask

    // left slot (first bit already sent), right slot, then the bit that closes right
    task automatic frame(input int n, input logic [63:0] l, input logic [63:0] r);
        send_slot(1'b0, l, n, 1'b1);
        send_slot(1'b1, r, n, 1'b0);
        send_bit(1'b0, carry);
        repeat (3) @(negedge clkin);
    endtask

    task automatic expect_pair(input string name, input logic [23:0] el, input logic [23:0] er);
        chk({name, " count"}, 64'(cap_l.size()), 64'd1);
        if (cap_l.size() > 0) begin
            chk({name, " left"}, 64'(cap_l[0]), 64'(el));
            chk({name, " right"}, 64'(cap_r[0]), 64'(er));
        end
        cap_l.delete();
        cap_r.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clkin); reset = 1'b1;
        @(negedge clkin); reset = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, " out_valid"}, 64'(out_valid), 64'd0);
        chk({name, " out_left"}, 64'(out_left), 64'd0);
        chk({name, " out_right"}, 64'(out_right), 64'd0);
        chk({name, " locked"}, 64'(locked), 64'd0);
        chk({name, " overflow"}, 64'(overflow), 64'd0);
        chk({name, " slot_err"}, 64'(slot_err), 64'd0);
    endtask

    int o0, s0;
    logic [63:0] w;

    initial begin
        tbl[0] = '{32, 16, 64'h123456A5,   64'hABCDEF5A,   24'h123456, 24'hABCDEF, 0};
        tbl[1] = '{32, 16, 64'hFFFFFF00,   64'h000000FF,   24'hFFFFFF, 24'h000000, 0};
        tbl[2] = '{24, 4,  64'h800001,     64'h7FFFFE,     24'h800001, 24'h7FFFFE, 0};
        tbl[3] = '{16, 4,  64'h8001,       64'h1234,       24'h800100, 24'h123400, 2};
        tbl[4] = '{20, 4,  64'hABCDE,      64'h12345,      24'hABCDE0, 24'h123450, 2};
        tbl[5] = '{40, 4,  64'h5A5A5AFFFF, 64'hC3C3C30000, 24'h5A5A5A, 24'hC3C3C3, 0};
        tbl[6] = '{23, 4,  64'h7FFFFF,     64'h400001,     24'hFFFFFE, 24'h800002, 2};

        // reset state
        repeat (4) @(negedge clkin);
        chk_outputs_zero("reset");
        chk("reset state", 64'(dut.state), 64'(HUNT));
        reset = 1'b0;
        @(negedge clkin);

        // partial first frame: right slot only, discarded
        bhalf = 16;
        send_slot(1'b1, 64'hDEADBEEF, 32, 1'b0);
        send_bit(1'b0, carry);
        repeat (3) @(negedge clkin);
        chk("warmup pairs", 64'(cap_l.size()), 64'd0);
        chk("warmup locked", 64'(locked), 64'd0);

        // table of frames, consumer always ready
        for (int i = 0; i < 7; i++) begin
            bhalf = tbl[i].bh;
            s0 = serr_cnt;
            frame(tbl[i].n, tbl[i].l, tbl[i].r);
            expect_pair($sformatf("vec%0d", i), tbl[i].el, tbl[i].er);
            chk($sformatf("vec%0d slot_err", i), 64'(serr_cnt - s0), 64'(tbl[i].serr));
            chk($sformatf("vec%0d locked", i), 64'(locked), 64'd1);
        end

        // backpressure: A held, B dropped, ready raised as C completes
        bhalf = 4;
        out_ready = 1'b0;
        o0 = ovf_cnt;
        frame(32, 64'h11111100, 64'h22222200);
        chk("bp A valid", 64'(out_valid), 64'd1);
        chk("bp A left", 64'(out_left), 64'h111111);
        chk("bp A right", 64'(out_right), 64'h222222);
        frame(32, 64'h33333300, 64'h44444400);
        chk("bp B overflow", 64'(ovf_cnt - o0), 64'd1);
        chk("bp B left kept", 64'(out_left), 64'h111111);
        chk("bp B right kept", 64'(out_right), 64'h222222);
        chk("bp B no transfer", 64'(cap_l.size()), 64'd0);
        o0 = ovf_cnt;
        send_slot(1'b0, 64'h55555500, 32, 1'b1);
        send_slot(1'b1, 64'h66666600, 32, 1'b0);
        bclk = 1'b0; lrck = 1'b0; sdin = carry;
        repeat (bhalf) @(negedge clkin);
        bclk = 1'b1;
        repeat (2) @(negedge clkin);
        out_ready = 1'b1;
        repeat (6) @(negedge clkin);
        chk("bp C overflow", 64'(ovf_cnt - o0), 64'd0);
        chk("bp C transfers", 64'(cap_l.size()), 64'd2);
        if (cap_l.size() == 2) begin
            chk("bp first left", 64'(cap_l[0]), 64'h111111);
            chk("bp first right", 64'(cap_r[0]), 64'h222222);
            chk("bp second left", 64'(cap_l[1]), 64'h555555);
            chk("bp second right", 64'(cap_r[1]), 64'h666666);
        end
        cap_l.delete();
        cap_r.delete();

        // timeout: BCLK stops mid right slot
        send_slot(1'b0, 64'h77777700, 32, 1'b1);
        w = 64'h88888800;
        for (int j = 0; j < 10; j++) send_bit(1'b1, (j == 0) ? carry : w[32-j]);
        repeat (300) @(negedge clkin);
        chk("tmo locked", 64'(locked), 64'd0);
        chk("tmo state", 64'(dut.state), 64'(HUNT));
        chk("tmo no pair", 64'(cap_l.size()), 64'd0);
        for (int j = 10; j < 32; j++) send_bit(1'b1, w[32-j]);
        carry = w[0];
        send_bit(1'b0, carry);
        repeat (3) @(negedge clkin);
        chk("tmo resume no pair", 64'(cap_l.size()), 64'd0);
        chk("tmo resume locked", 64'(locked), 64'd0);
        frame(32, 64'h99999900, 64'hAAAAAA00);
        expect_pair("relock", 24'h999999, 24'hAAAAAA);
        chk("relock locked", 64'(locked), 64'd1);

        // reset during a left slot
        w = 64'hBBBBBB00;
        for (int j = 1; j < 9; j++) send_bit(1'b0, w[32-j]);
        pulse_reset();
        #2;
        chk_outputs_zero("midreset");
        @(negedge clkin);
        for (int j = 9; j < 32; j++) send_bit(1'b0, w[32-j]);
        carry = w[0];
        send_slot(1'b1, 64'hCCCCCC00, 32, 1'b0);
        send_bit(1'b0, carry);
        repeat (3) @(negedge clkin);
        chk("midreset no pair", 64'(cap_l.size()), 64'd0);
        frame(32, 64'h0F0F0F00, 64'hF0F0F000);
        expect_pair("after reset", 24'h0F0F0F, 24'hF0F0F0);

        // orphan right slot right after reset
        pulse_reset();
        send_slot(1'b1, 64'hDDDDDD00, 32, 1'b0);
        send_bit(1'b0, carry);
        send_slot(1'b0, 64'h13579B00, 32, 1'b1);
        repeat (3) @(negedge clkin);
        chk("orphan no pair", 64'(cap_l.size()), 64'd0);
        send_slot(1'b1, 64'h2468AC00, 32, 1'b0);
        send_bit(1'b0, carry);
        repeat (3) @(negedge clkin);
        expect_pair("orphan", 24'h13579B, 24'h2468AC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
